// File: rtl/input_guard_pkg.sv
// Shared constants and types for the input guard bank.
// The channel-to-top edge record keeps rise/fall pulses paired.
package input_guard_pkg;

  localparam int IG_SYNC_STAGES_DEF = 2;
  localparam int IG_FILT_BITS_DEF   = 3;

  typedef struct packed {
    logic rise;
    logic fall;
  } ig_edge_t;

endpackage

// File: rtl/input_guard_chan.sv
// One input guard channel: synchroniser chain, qualification counter,
// filtered level register and registered rise/fall pulses.
module input_guard_chan
  import input_guard_pkg::*;
#(
  parameter int SYNC_STAGES = IG_SYNC_STAGES_DEF,
  parameter int FILT_BITS   = IG_FILT_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in,
  input  logic                 i_en,
  input  logic [FILT_BITS-1:0] i_thresh,
  output logic                 o_z,
  output ig_edge_t             o_edge
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  logic [FILT_BITS-1:0] r_cnt;
  logic                 r_z;
  ig_edge_t             r_edge;

  logic                 w_s;
  logic                 w_diff;
  logic                 w_qual;
  logic [FILT_BITS-1:0] w_cnt_next;
  logic                 w_z_next;
  ig_edge_t             w_edge_next;

  // The chain keeps sampling while disabled so re-enable sees current data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = w_s ^ r_z;
  assign w_qual = (r_cnt >= i_thresh);

  always_comb begin
    w_cnt_next  = '0;
    w_z_next    = r_z;
    w_edge_next = '0;
    if (i_en && w_diff) begin
      if (w_qual) begin
        w_z_next         = w_s;
        w_edge_next.rise = w_s;
        w_edge_next.fall = ~w_s;
      end else begin
        // Cannot wrap: the compare fires no later than the all-ones count.
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_z    <= 1'b0;
      r_edge <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_z    <= w_z_next;
      r_edge <= w_edge_next;
    end
  end

  assign o_z    = r_z;
  assign o_edge = r_edge;

endmodule

// File: rtl/input_guard_bank.sv
// Multi-channel input conditioner: WIDTH independent guard channels plus
// a registered any-edge flag that trails the per-channel pulses by one cycle.
module input_guard_bank
  import input_guard_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = IG_SYNC_STAGES_DEF,
  parameter int FILT_BITS   = IG_FILT_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     I,
  input  logic [WIDTH-1:0]     EN,
  input  logic [FILT_BITS-1:0] THRESH,
  output logic [WIDTH-1:0]     Z,
  output logic [WIDTH-1:0]     RISE,
  output logic [WIDTH-1:0]     FALL,
  output logic                 CHG
);

  ig_edge_t w_edge [WIDTH];
  logic     r_chg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    input_guard_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_BITS   (FILT_BITS)
    ) u_chan (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_in     (I[gi]),
      .i_en     (EN[gi]),
      .i_thresh (THRESH),
      .o_z      (Z[gi]),
      .o_edge   (w_edge[gi])
    );
    assign RISE[gi] = w_edge[gi].rise;
    assign FALL[gi] = w_edge[gi].fall;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= |(RISE | FALL);
    end
  end

  assign CHG = r_chg;

endmodule

// File: tb/tb_input_guard_bank.sv
// Directed plus randomized bench for input_guard_bank against a
// run-length behavioural model of the qualification rules.
module tb_input_guard_bank;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int FB = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  I;
  logic [W-1:0]  EN;
  logic [FB-1:0] THRESH;
  logic [W-1:0]  Z, RISE, FALL;
  logic          CHG;

  int checks   = 0;
  int failures = 0;

  input_guard_bank #(.WIDTH(W), .SYNC_STAGES(SS), .FILT_BITS(FB)) dut (
    .CLK(CLK), .RST(RST), .I(I), .EN(EN), .THRESH(THRESH),
    .Z(Z), .RISE(RISE), .FALL(FALL), .CHG(CHG)
  );

  always #5 CLK = ~CLK;

  // Model: s is I delayed by SS sampled edges; Z flips once a run of
  // differing samples exceeds THRESH; any match or disable ends the run.
  logic [W-1:0] m_hist [SS];
  logic [W-1:0] m_z, m_rise, m_fall;
  logic         m_chg;
  int           m_run [W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] s;
    if (RST) begin
      for (int k = 0; k < SS; k++) m_hist[k] = '0;
      for (int n = 0; n < W; n++) m_run[n] = 0;
      m_z = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      return;
    end
    m_chg = |(m_rise | m_fall);
    s = m_hist[SS-1];
    m_rise = '0;
    m_fall = '0;
    for (int n = 0; n < W; n++) begin
      if (EN[n] && (s[n] != m_z[n])) begin
        m_run[n] = m_run[n] + 1;
        if (m_run[n] > int'(THRESH)) begin
          m_z[n] = s[n];
          if (s[n]) m_rise[n] = 1'b1; else m_fall[n] = 1'b1;
          m_run[n] = 0;
        end
      end else begin
        m_run[n] = 0;
      end
    end
    for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = I;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
    chk("z",    32'(Z),    32'(m_z));
    chk("rise", 32'(RISE), 32'(m_rise));
    chk("fall", 32'(FALL), 32'(m_fall));
    chk("chg",  32'(CHG),  32'(m_chg));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  logic saw_rise;

  initial begin
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    for (int n = 0; n < W; n++) m_run[n] = 0;
    m_z = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;

    // Reset then rise qualification on all channels
    RST = 1'b1; I = 4'hF; EN = 4'hF; THRESH = 3'd3;
    ticks(2);
    chk("rst_z", 32'(Z), 32'h0);
    chk("rst_chg", 32'(CHG), 32'h0);
    RST = 1'b0;
    ticks(5);
    chk("rise_early_z", 32'(Z), 32'h0);
    tick();
    chk("rise_edge6_z", 32'(Z), 32'hF);
    chk("rise_edge6_rise", 32'(RISE), 32'hF);
    tick();
    chk("rise_chg", 32'(CHG), 32'h1);
    chk("rise_pulse_end", 32'(RISE), 32'h0);
    $display("step reset/rise done checks=%0d", checks);

    // Glitch rejection
    I = 4'h0; ticks(8);
    I = 4'h1; ticks(3);
    I = 4'h0;
    saw_rise = 1'b0;
    for (int k = 0; k < 8; k++) begin tick(); if (RISE[0]) saw_rise = 1'b1; end
    chk("glitch3_z0", 32'(Z[0]), 32'h0);
    chk("glitch3_norise", 32'(saw_rise), 32'h0);
    I = 4'h1; ticks(4);
    I = 4'h0;
    saw_rise = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (RISE[0]) saw_rise = 1'b1; end
    chk("glitch4_rise", 32'(saw_rise), 32'h1);
    chk("glitch4_z0", 32'(Z[0]), 32'h1);
    ticks(4);
    chk("glitch4_fall_z0", 32'(Z[0]), 32'h0);
    $display("step glitch done checks=%0d", checks);

    // THRESH = 0: three-edge lag
    THRESH = 3'd0; ticks(3);
    I = 4'h2; ticks(2);
    chk("t0_lag2", 32'(Z[1]), 32'h0);
    tick();
    chk("t0_lag3", 32'(Z[1]), 32'h1);
    for (int k = 0; k < 12; k++) begin I = 4'($urandom); tick(); end
    I = 4'h0; ticks(4);

    // THRESH = 7: eighth differing sample updates
    THRESH = 3'd7; I = 4'h1;
    ticks(9);
    chk("t7_z0_hold", 32'(Z[0]), 32'h0);
    tick();
    chk("t7_z0_upd", 32'(Z[0]), 32'h1);
    I = 4'h0; ticks(12);

    // Lower THRESH mid-qualification
    I = 4'h1; ticks(2); ticks(5);
    chk("drop_before", 32'(Z[0]), 32'h0);
    THRESH = 3'd2; tick();
    chk("drop_after", 32'(Z[0]), 32'h1);
    $display("step thresh done checks=%0d", checks);

    // Enable gating
    THRESH = 3'd3; I = 4'h0; ticks(8);
    EN = 4'b1011;
    for (int k = 0; k < 6; k++) begin I[2] = ~I[2]; tick(); end
    I[2] = 1'b1; ticks(4);
    chk("en_hold_z2", 32'(Z[2]), 32'h0);
    EN = 4'hF; ticks(3);
    chk("en_wait_z2", 32'(Z[2]), 32'h0);
    tick();
    chk("en_upd_z2", 32'(Z[2]), 32'h1);
    $display("step enable done checks=%0d", checks);

    // Reset mid-qualification
    I = 4'b0110; ticks(4);
    RST = 1'b1; tick();
    chk("rstmid_z", 32'(Z), 32'h0);
    chk("rstmid_rise", 32'(RISE), 32'h0);
    RST = 1'b0;
    ticks(5);
    chk("rstmid_wait", 32'(Z[1]), 32'h0);
    tick();
    chk("rstmid_upd", 32'(Z[1]), 32'h1);
    $display("step reset-mid done checks=%0d", checks);

    // Simultaneous rise on ch0 and fall on ch3
    I = 4'b1000; ticks(8);
    I = 4'b0001; ticks(6);
    chk("multi_rise", 32'(RISE), 32'h1);
    chk("multi_fall", 32'(FALL), 32'h8);
    tick();
    chk("multi_chg", 32'(CHG), 32'h1);
    tick();
    chk("multi_chg_end", 32'(CHG), 32'h0);
    $display("step multi done checks=%0d", checks);

    // Randomized soak
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) I = I ^ 4'($urandom);
      if ($urandom_range(0, 15) == 0) EN = 4'($urandom);
      if ($urandom_range(0, 31) == 0) THRESH = 3'($urandom);
      RST = ($urandom_range(0, 99) == 0);
      tick();
    end
    RST = 1'b0;
    $display("step random done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_guard_bank.md
# input_guard_bank

Parametrised, multi-channel input conditioner for pad-side signals that enter the core through antenna-protected inputs. Each channel synchronises an asynchronous input, rejects glitches shorter than a programmable qualification time, and produces a clean registered level plus one-cycle rise and fall pulses. The block sits between the input pad/antenna cells and core logic, and replaces ad-hoc per-pin synchronisers.

## Interface
- `WIDTH`, default 4: number of independent channels, minimum 1.
- `SYNC_STAGES`, default 2: synchroniser flop depth, minimum 2.
- `FILT_BITS`, default 3: width of the qualification counter and of `THRESH`.

- `CLK`  in  1: single block clock; all state updates on its rising edge.
- `RST`  in  1: reset, synchronous and active-high.
- `I`  in  WIDTH: raw asynchronous inputs, one bit per channel.
- `EN`  in  WIDTH: per-channel enable, synchronous to `CLK`.
- `THRESH`  in  FILT_BITS: qualification threshold shared by all channels, synchronous to `CLK`.
- `Z`  out  WIDTH: filtered, registered level per channel.
- `RISE`  out  WIDTH: one-cycle pulse when `Z` goes 0→1.
- `FALL`  out  WIDTH: one-cycle pulse when `Z` goes 1→0.
- `CHG`  out  1: registered OR of all `RISE` and `FALL` bits.

## Operation
- Per channel: an `SYNC_STAGES`-deep flop chain on `I[n]` gives `s[n]`. A `FILT_BITS`-wide counter `cnt[n]` holds the number of consecutive prior cycles in which `s[n] != Z[n]`.
- Each cycle with `EN[n]=1`:
  - If `s[n] == Z[n]`: `cnt[n]` is set to 0.
  - If `s[n] != Z[n]` and `cnt[n] >= THRESH`: `Z[n]` is set to `s[n]`, `cnt[n]` is set to 0, and `RISE[n]` or `FALL[n]` is asserted for exactly that next cycle.
  - If `s[n] != Z[n]` and `cnt[n] < THRESH`: `cnt[n]` is incremented. The counter never wraps, because the `>=` test fires at or before `2^FILT_BITS-1`.
- `Z[n]` therefore changes only after `THRESH+1` consecutive differing samples. Any matching sample restarts qualification.
- `THRESH=0`: no filtering; `Z` follows `s` one cycle later.
- Lowering `THRESH` mid-qualification takes effect on the next compare. If `cnt` is already at or above the new value, `Z` updates that cycle.
- `EN[n]=0`:
  - `Z[n]` is held.
  - `cnt[n]` is forced to 0.
  - `RISE[n]` and `FALL[n]` are 0.
  - The synchroniser keeps sampling, so re-enable uses current data with no stale-sync hazard.
- `RST=1` sets every synchroniser flop, every `cnt`, and all of `Z`, `RISE`, `FALL` and `CHG` to 0 on the next edge. This overrides `EN` and any in-progress qualification. After reset, a high input qualifies as a rise.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse, and `CHG` is asserted once for that cycle.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency from a stable `I` change (set up before edge 1) to the `Z`/`RISE`/`FALL` update is `SYNC_STAGES + THRESH + 1` edges. With defaults and `THRESH=3`, that is 6 edges.
- `CHG` lags `RISE`/`FALL` by one cycle.
- Maximum rejected glitch: any pulse on `s` lasting at most `THRESH` cycles never reaches `Z`.
- Reset values: `Z`, `RISE`, `FALL` = 0 (WIDTH bits each); `CHG` = 0.
- Minimum reset assertion is 1 cycle. The first possible `Z` update after reset release comes `SYNC_STAGES + THRESH + 1` edges later.

## Structure
- A shared package `input_guard_pkg` holds the default-parameter constants (`IG_SYNC_STAGES_DEF`, `IG_FILT_BITS_DEF`) and a `ig_edge_t` struct `{rise, fall}` used between the channel and the top level.
- Sub-module `input_guard_chan` contains one channel: synchroniser, counter, `Z` register and edge pulses. The top level instantiates it `WIDTH` times in a generate loop and builds the `CHG` OR-reduce register.
- The synchroniser flops carry the team's synchroniser attribute so that the chain is not retimed and is recognised by CDC checks.

## Test plan
- Reset and rise qualification: hold `RST=1` for 2 cycles with `I=4'hF`, `EN=4'hF`, `THRESH=3` → all outputs are 0 during reset; `Z=4'hF` and `RISE=4'hF` exactly 6 edges after release; `CHG=1` one cycle later.
- Glitch rejection: `THRESH=3`, `Z[0]=0`, drive a 3-cycle high pulse on `I[0]` → `Z[0]` stays 0 and there is no `RISE`. A 4-cycle pulse → `Z[0]=1` with a one-cycle `RISE[0]`; `FALL[0]` follows once the low has qualified.
- `THRESH` boundaries: with `THRESH=0`, `Z` tracks `I` with a 3-edge lag. With `THRESH=7`, 7 differing samples are rejected and the 8th updates `Z`. Dropping `THRESH` from 7 to 2 while `cnt=5` → `Z` updates on the next edge.
- Enable gating: toggle `I[2]` while `EN[2]=0` → `Z[2]` holds and no pulses occur. Raise `EN[2]` with `s[2]` already differing → `Z[2]` updates `THRESH+1` cycles later.
- Reset mid-qualification: assert `RST` when `cnt[1]=2` → the next edge clears `Z`, `cnt` and the pulses; after release, qualification restarts from 0.
- Multi-channel: rise on channel 0 and fall on channel 3 in the same cycle → `RISE=4'b0001` and `FALL=4'b1000` in the same cycle; `CHG` is a single one-cycle pulse.
